// File: rtl/cpu_pkg.sv
// Shared widths, fetch FSM states and the IF/ID bundle for the fetch/decode slice.
package cpu_pkg;

    localparam int OPCODE_W  = 4;
    localparam int OPERAND_W = 3;
    localparam int IMM_W     = 8;
    localparam int INSTR_W   = 9;
    localparam int PC_W      = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]      pc;
        logic                 format;
        logic [OPCODE_W-1:0]  opcode;
        logic                 sign;
        logic [OPERAND_W-1:0] operand;
        logic [IMM_W-1:0]     immediate;
    } if_id_t;

    // PC arithmetic wraps modulo 2^PC_W.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + {{(PC_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush clears only the valid bit, hold freezes everything.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   flush,
    input  logic   hold,
    input  if_id_t d,
    output if_id_t q,
    output logic   valid
);

    // Priority: reset > flush > hold > capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (!hold) begin
            q     <= d;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, IDLE/RUN/HALT control and IF/ID capture of the ROM fields.
// Optional performance counters are built when INSTR_FETCH_PERF_EN is defined.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] PROG_LEN = 16'd35,
    parameter logic [PC_W-1:0] RESET_PC = 16'd0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [PC_W-1:0]      branch_target,
    output logic [PC_W-1:0]      pc_out,
    input  logic                 rom_format,
    input  logic [OPCODE_W-1:0]  rom_opcode,
    input  logic                 rom_sign,
    input  logic [OPERAND_W-1:0] rom_operand,
    input  logic [IMM_W-1:0]     rom_immediate,
    output logic                 if_valid,
    output logic [PC_W-1:0]      if_pc,
    output logic [INSTR_W-1:0]   if_instr,
    output logic                 if_format,
    output logic [OPCODE_W-1:0]  if_opcode,
    output logic                 if_sign,
    output logic [OPERAND_W-1:0] if_operand,
    output logic [IMM_W-1:0]     if_immediate,
    output logic                 halted,
    output logic                 busy,
`ifdef INSTR_FETCH_PERF_EN
    output logic [15:0]          perf_fetched,
    output logic [15:0]          perf_bubbles,
`endif
    output fetch_state_t         fetch_state
);

    // Handshake: stall is the only back-pressure. While high in RUN (no branch) the
    // PC and IF/ID hold; if_valid high means if_* carries a live instruction this cycle.
    logic   [PC_W-1:0] pc;
    fetch_state_t      state;
    logic              running;
    logic              at_end;
    logic              flush;
    logic              hold;
    if_id_t            fetch_word;
    if_id_t            if_id;

    assign running = (state == RUN);
    assign at_end  = (pc >= PROG_LEN);
    assign flush   = running && (branch_taken || at_end);
    assign hold    = !running || stall;

    assign fetch_word = '{pc: pc, format: rom_format, opcode: rom_opcode, sign: rom_sign,
                          operand: rom_operand, immediate: rom_immediate};

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            halted <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (branch_taken) begin
                        pc <= branch_target;
                    end else if (at_end) begin
                        state  <= HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else if (!stall) begin
                        pc <= pc_inc(pc);
                    end
                end
                HALT: ;
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .hold  (hold),
        .d     (fetch_word),
        .q     (if_id),
        .valid (if_valid)
    );

`ifdef INSTR_FETCH_PERF_EN
    // Both counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= 16'd0;
            perf_bubbles <= 16'd0;
        end else begin
            if (!flush && !hold && perf_fetched != 16'hFFFF)
                perf_fetched <= perf_fetched + 16'd1;
            if (running && (branch_taken || stall) && perf_bubbles != 16'hFFFF)
                perf_bubbles <= perf_bubbles + 16'd1;
        end
    end
`endif

    assign pc_out       = pc;
    assign fetch_state  = state;
    assign if_pc        = if_id.pc;
    assign if_format    = if_id.format;
    assign if_opcode    = if_id.opcode;
    assign if_sign      = if_id.sign;
    assign if_operand   = if_id.operand;
    assign if_immediate = if_id.immediate;
    assign if_instr     = {if_id.format, if_id.immediate};

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then random stall/branch traffic against a reference model.
// Define INSTR_FETCH_PERF_EN to also check the performance counters.
module tb_instr_fetch;
    import cpu_pkg::*;

    localparam int LEN = 35;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'd0;
    logic [15:0] pc_out;
    logic        if_valid, if_format, if_sign, halted, busy;
    logic [15:0] if_pc;
    logic [8:0]  if_instr;
    logic [3:0]  if_opcode;
    logic [2:0]  if_operand;
    logic [7:0]  if_immediate;
    fetch_state_t fetch_state;
`ifdef INSTR_FETCH_PERF_EN
    logic [15:0] perf_fetched, perf_bubbles;
`endif

    logic [8:0] rom [0:LEN-1];
    logic [8:0] rom_word;
    assign rom_word = (int'(pc_out) < LEN) ? rom[int'(pc_out)] : 9'h000;

    instr_fetch dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target), .pc_out(pc_out),
        .rom_format(rom_word[8]), .rom_opcode(rom_word[7:4]), .rom_sign(rom_word[3]),
        .rom_operand(rom_word[2:0]), .rom_immediate(rom_word[7:0]),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_format(if_format),
        .if_opcode(if_opcode), .if_sign(if_sign), .if_operand(if_operand),
        .if_immediate(if_immediate), .halted(halted), .busy(busy),
`ifdef INSTR_FETCH_PERF_EN
        .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles),
`endif
        .fetch_state(fetch_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: program position, whether fetching is live or finished, last fetched instruction.
    bit          m_run, m_halt, m_valid;
    int          m_pc;
    int          m_ifpc;
    logic [8:0]  m_instr;
    int          m_fetched, m_bubbles;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] rom_at(input int pc);
        return (pc < LEN) ? rom[pc] : 9'h000;
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_run = 0; m_halt = 0; m_pc = 0; m_valid = 0;
            m_ifpc = 0; m_instr = 9'h000; m_fetched = 0; m_bubbles = 0;
        end else if (!m_run && !m_halt) begin
            if (start) m_run = 1;
        end else if (m_run) begin
            if ((branch_taken || stall) && m_bubbles < 65535) m_bubbles++;
            if (branch_taken) begin
                m_pc = int'(branch_target);
                m_valid = 0;
            end else if (m_pc >= LEN) begin
                m_valid = 0;
                m_run = 0;
                m_halt = 1;
            end else if (!stall) begin
                m_ifpc = m_pc;
                m_instr = rom_at(m_pc);
                m_valid = 1;
                m_pc = (m_pc + 1) % 65536;
                if (m_fetched < 65535) m_fetched++;
            end
        end
    endtask

    task automatic check_all();
        fetch_state_t exp_state;
        exp_state = m_halt ? HALT : (m_run ? RUN : IDLE);
        chk("pc_out", 32'(pc_out), 32'(m_pc));
        chk("if_valid", 32'(if_valid), 32'(m_valid));
        chk("halted", 32'(halted), 32'(m_halt));
        chk("busy", 32'(busy), 32'(m_run));
        chk("state", 32'(fetch_state), 32'(exp_state));
        if (m_valid) begin
            chk("if_pc", 32'(if_pc), 32'(m_ifpc));
            chk("if_instr", 32'(if_instr), 32'(m_instr));
            chk("if_format", 32'(if_format), 32'(m_instr[8]));
            chk("if_opcode", 32'(if_opcode), 32'(m_instr[7:4]));
            chk("if_sign", 32'(if_sign), 32'(m_instr[3]));
            chk("if_operand", 32'(if_operand), 32'(m_instr[2:0]));
            chk("if_immediate", 32'(if_immediate), 32'(m_instr[7:0]));
        end
`ifdef INSTR_FETCH_PERF_EN
        chk("perf_fetched", 32'(perf_fetched), 32'(m_fetched));
        chk("perf_bubbles", 32'(perf_bubbles), 32'(m_bubbles));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run_until_pc(input int target);
        int n = 0;
        while (int'(pc_out) != target && n < 100) begin
            step();
            n++;
        end
        if (int'(pc_out) != target) chk("timeout_pc", 32'(pc_out), 32'(target));
    endtask

    initial begin
        for (int i = 0; i < LEN; i++) rom[i] = 9'((i * 53 + 11) % 512);
        rom[0] = 9'h001;
        rom[3] = 9'h071;
        rom[28] = 9'h034;

        // Reset state
        reset = 1'b1;
        step();
        step();
        chk("rst_if_pc", 32'(if_pc), 32'd0);
        chk("rst_if_instr", 32'(if_instr), 32'd0);
        chk("rst_if_opcode", 32'(if_opcode), 32'd0);
        chk("rst_if_operand", 32'(if_operand), 32'd0);
        chk("rst_if_sign", 32'(if_sign), 32'd0);

        // Start, first fetches
        reset = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("first_if_pc", 32'(if_pc), 32'd0);
        chk("first_if_instr", 32'(if_instr), 32'h001);
        chk("first_valid", 32'(if_valid), 32'd1);
        run_until_pc(4);
        chk("pc3_if_pc", 32'(if_pc), 32'd3);
        chk("pc3_if_instr", 32'(if_instr), 32'h071);
        chk("pc3_if_opcode", 32'(if_opcode), 32'd7);
        chk("pc3_if_operand", 32'(if_operand), 32'd1);

        // Stall three cycles at PC 5
        run_until_pc(5);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", 32'(pc_out), 32'd5);
            chk("stall_if_pc", 32'(if_pc), 32'd4);
        end
        stall = 1'b0;
        step();
        chk("unstall_if_pc5", 32'(if_pc), 32'd5);
        step();
        chk("unstall_if_pc6", 32'(if_pc), 32'd6);

        // Branch to 28 from PC 12
        run_until_pc(12);
        branch_taken = 1'b1;
        branch_target = 16'd28;
        step();
        branch_taken = 1'b0;
        chk("br_bubble_valid", 32'(if_valid), 32'd0);
        chk("br_pc", 32'(pc_out), 32'd28);
        step();
        chk("br_target_instr", 32'(if_instr), 32'h034);

        // Branch and stall together: branch wins
        branch_taken = 1'b1;
        stall = 1'b1;
        branch_target = 16'd20;
        step();
        branch_taken = 1'b0;
        stall = 1'b0;
        chk("brstall_valid", 32'(if_valid), 32'd0);
        chk("brstall_pc", 32'(pc_out), 32'd20);

        // Run to the end of the program
        run_until_pc(LEN);
        chk("end_if_pc", 32'(if_pc), 32'd34);
        step();
        chk("end_valid", 32'(if_valid), 32'd0);
        chk("end_pc_hold", 32'(pc_out), 32'(LEN));
        step();
        chk("end_halted", 32'(halted), 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("halt_sticky", 32'(halted), 32'd1);
        chk("halt_pc", 32'(pc_out), 32'(LEN));

        // Randomized traffic with occasional resets and out-of-range branch targets
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 600; i++) begin
            start = (!busy && $urandom_range(0, 3) == 0);
            if (halted && $urandom_range(0, 3) == 0) reset = 1'b1;
            else reset = ($urandom_range(0, 199) == 0);
            stall = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 6) == 0);
            branch_target = 16'($urandom_range(0, LEN + 5));
            step();
        end
        reset = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;

        // Reset mid-run at PC 17
        reset = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        run_until_pc(17);
        reset = 1'b1;
        stall = 1'b1;
        branch_taken = 1'b1;
        step();
        reset = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        chk("midrst_pc", 32'(pc_out), 32'd0);
        chk("midrst_state", 32'(fetch_state), 32'(IDLE));
        chk("midrst_valid", 32'(if_valid), 32'd0);
`ifdef INSTR_FETCH_PERF_EN
        chk("midrst_perf_fetched", 32'(perf_fetched), 32'd0);
        chk("midrst_perf_bubbles", 32'(perf_bubbles), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
